// File: rtl/aes_arb_pkg.sv
// Shared widths and FSM state encoding for the AES core arbiter.
package aes_arb_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

endpackage

// File: rtl/aes_core_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo N. Reusable outside the AES arbiter.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(ptr_i) + off) % N);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin front end sharing one AES-128 core among NUM_REQ requesters.
// Define AES_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_plaintext,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [AES_BLK_W-1:0]           rsp_ciphertext,
  output logic                           rsp_err,
  output logic                           core_start,
  output logic [AES_KEY_W-1:0]           core_key,
  output logic [AES_BLK_W-1:0]           core_plaintext,
  input  logic [AES_BLK_W-1:0]           core_ciphertext,
  input  logic                           core_valid
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("aes_core_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
  end

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [AES_BLK_W-1:0] pt_q, pt_d;
  logic [AES_BLK_W-1:0] ct_q, ct_d;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 timeout_hit;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  // Grants are offered only in IDLE, so at most one block is ever in flight.
  assign req_ready      = (state_q == IDLE && !rst) ? arb_grant : '0;
  assign core_start     = (state_q == ISSUE);
  assign rsp_valid      = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign core_key       = key_q;
  assign core_plaintext = pt_q;
  assign rsp_ciphertext = ct_q;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;

  assign timeout_hit = (state_q == WAIT) && (wait_cnt_q >= CW'(TIMEOUT_CYCLES));
  assign rsp_err     = err_q;

  // Counter sits at zero outside WAIT so every WAIT visit starts fresh.
  always_comb begin
    wait_cnt_d = '0;
    err_d      = err_q;
    if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
      if (core_valid) begin
        err_d = 1'b0;
      end else if (timeout_hit) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    key_d    = key_q;
    pt_d     = pt_q;
    ct_d     = ct_q;
    case (state_q)
      IDLE: begin
        if (|(req_valid & req_ready)) begin
          gnt_d   = arb_idx;
          key_d   = req_key[int'(arb_idx)*AES_KEY_W +: AES_KEY_W];
          pt_d    = req_plaintext[int'(arb_idx)*AES_BLK_W +: AES_BLK_W];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A real result beats a timeout landing in the same cycle.
        if (core_valid) begin
          ct_d    = core_ciphertext;
          state_d = RESP;
        end else if (timeout_hit) begin
          ct_d    = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          rr_ptr_d = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + IW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      key_q    <= '0;
      pt_q     <= '0;
      ct_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      key_q    <= key_d;
      pt_q     <= pt_d;
      ct_q     <= ct_d;
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter with a behavioural AES-128 core.
// Build with AES_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_aes_core_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*128-1:0] req_key, req_plaintext;
  logic [127:0]     rsp_ciphertext, core_key, core_plaintext, core_ciphertext;
  logic             rsp_err, core_start, core_valid;

  int checks  = 0;
  int errors  = 0;
  int exp_ptr = 0;
  logic [7:0] sbox_tab [256];

  always #5 clk = ~clk;

  aes_core_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_key         (req_key),
    .req_plaintext   (req_plaintext),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_ciphertext  (rsp_ciphertext),
    .rsp_err         (rsp_err),
    .core_start      (core_start),
    .core_key        (core_key),
    .core_plaintext  (core_plaintext),
    .core_ciphertext (core_ciphertext),
    .core_valid      (core_valid)
  );

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, xb;
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon, a0, a1, a2, a3;
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [127:0] res;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox_tab[st[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) st[4*c+rw] = tmp[4*((c+rw)%4)+rw];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) st[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // ---------------- behavioural core ----------------
  logic [127:0] model_ct    = '0;
  logic [127:0] core_res    = '0;
  logic [127:0] spur_ct     = '0;
  logic         model_valid = 1'b0;
  logic         spur_valid  = 1'b0;
  logic         core_busy   = 1'b0;
  logic         core_mute   = 1'b0;
  int           core_delay  = 0;

  assign core_valid      = model_valid | spur_valid;
  assign core_ciphertext = spur_valid ? spur_ct : model_ct;

  always @(posedge clk) begin
    model_valid <= 1'b0;
    if (rst) begin
      core_busy <= 1'b0;
    end else if (core_start) begin
      core_busy  <= 1'b1;
      core_delay <= $urandom_range(1, 6);
      core_res   <= aes128(core_key, core_plaintext);
    end else if (core_busy) begin
      if (core_delay <= 1) begin
        core_busy <= 1'b0;
        if (!core_mute) begin
          model_valid <= 1'b1;
          model_ct    <= core_res;
        end
      end else begin
        core_delay <= core_delay - 1;
      end
    end
  end

  // ---------------- reference helpers ----------------
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] p);
    req_key[128*i +: 128]       = k;
    req_plaintext[128*i +: 128] = p;
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake(input int g);
    rsp_ready = oh(g);
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = '0; spur_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ptr = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b, expected 0", req_ready); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_start: got %b, expected 0", core_start); end
    checks++; if (core_key !== '0 || core_plaintext !== '0) begin errors++; $display("[TB] FAIL reset_core_data: got key %h pt %h, expected 0", core_key, core_plaintext); end
    checks++; if (rsp_ciphertext !== '0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_data: got ct %h err %b, expected 0", rsp_ciphertext, rsp_err); end
    rst = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    logic [127:0] k, p, ct_exp;
    int starts, cv_cyc, rsp_cyc;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    p = 128'h00112233445566778899aabbccddeeff;
    ct_exp = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    @(negedge clk);
    set_req(0, k, p);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready: got %b, expected 0001", req_ready); end
    @(negedge clk);
    checks++; if (core_start !== 1'b1 || core_key !== k || core_plaintext !== p) begin errors++; $display("[TB] FAIL single_issue: got start %b key %h pt %h", core_start, core_key, core_plaintext); end
    req_valid = '0;
    starts = 1; cv_cyc = -1; rsp_cyc = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (core_start) starts++;
      if (rsp_valid != '0) begin rsp_cyc = c; break; end
      if (core_valid && cv_cyc < 0) cv_cyc = c;
    end
    checks++; if (rsp_cyc < 0 || cv_cyc < 0 || rsp_cyc != cv_cyc + 1) begin errors++; $display("[TB] FAIL single_latency: got rsp cycle %0d, core_valid cycle %0d, expected rsp one after", rsp_cyc, cv_cyc); end
    checks++; if (starts != 1) begin errors++; $display("[TB] FAIL single_start_pulses: got %0d, expected 1", starts); end
    checks++; if (rsp_valid !== 4'b0001 || rsp_ciphertext !== ct_exp || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp: got valid %b ct %h err %b, expected 0001 %h 0", rsp_valid, rsp_ciphertext, rsp_err, ct_exp); end
    handshake(0);
    checks++; if (rsp_valid !== '0) begin errors++; $display("[TB] FAIL single_rsp_drop: got %b, expected 0", rsp_valid); end
    exp_ptr = 1;
  endtask

  task automatic test_round_robin();
    logic [127:0] keys [N];
    logic [127:0] pts [N];
    logic [127:0] ct_exp;
    int g;
    bit got;
    do_reset();
    for (int i = 0; i < N; i++) begin
      keys[i] = rand128(); pts[i] = rand128(); set_req(i, keys[i], pts[i]);
    end
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      #1;
      g = model_pick(req_valid, exp_ptr);
      checks++; if (req_ready !== oh(g)) begin errors++; $display("[TB] FAIL rr_grant_%0d: got %b, expected %b", n, req_ready, oh(g)); end
      ct_exp = aes128(keys[g], pts[g]);
      @(negedge clk);
      if (n == 0) begin
        keys[0] = rand128(); pts[0] = rand128(); set_req(0, keys[0], pts[0]);
      end else begin
        req_valid[g] = 1'b0;
      end
      wait_rsp(got);
      checks++; if (!got || rsp_valid !== oh(g) || rsp_ciphertext !== ct_exp || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rr_rsp_%0d: got valid %b ct %h, expected %b %h", n, rsp_valid, rsp_ciphertext, oh(g), ct_exp); end
      repeat ($urandom_range(0, 3)) begin
        rsp_ready = N'($urandom) & ~oh(g);
        @(negedge clk);
      end
      checks++; if (rsp_valid !== oh(g)) begin errors++; $display("[TB] FAIL rr_rsp_hold_%0d: got %b, expected %b", n, rsp_valid, oh(g)); end
      handshake(g);
      exp_ptr = (g + 1) % N;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] k2, p2, k3, p3, ct2;
    bit got;
    k2 = rand128(); p2 = rand128(); k3 = rand128(); p3 = rand128();
    ct2 = aes128(k2, p2);
    @(negedge clk);
    set_req(2, k2, p2);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== oh(model_pick(4'b0100, exp_ptr))) begin errors++; $display("[TB] FAIL bp_grant2: got %b, expected 0100", req_ready); end
    @(negedge clk);
    set_req(3, k3, p3);
    req_valid = 4'b1000;
    wait_rsp(got);
    checks++; if (!got || rsp_valid !== 4'b0100) begin errors++; $display("[TB] FAIL bp_rsp2: got %b, expected 0100", rsp_valid); end
    for (int c = 0; c < 10; c++) begin
      rsp_ready = N'($urandom) & ~oh(2);
      @(negedge clk);
      checks++; if (rsp_valid !== 4'b0100 || rsp_ciphertext !== ct2 || req_ready !== '0) begin errors++; $display("[TB] FAIL bp_hold_%0d: got valid %b ct %h ready %b, expected 0100 %h 0000", c, rsp_valid, rsp_ciphertext, req_ready, ct2); end
    end
    rsp_ready = oh(2);
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL bp_ready_at_hs: got %b, expected 0", req_ready); end
    @(negedge clk);
    rsp_ready = '0;
    exp_ptr = 3;
    #1;
    checks++; if (req_ready !== oh(model_pick(req_valid, exp_ptr))) begin errors++; $display("[TB] FAIL bp_grant3: got %b, expected 1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(got);
    checks++; if (!got || rsp_valid !== 4'b1000 || rsp_ciphertext !== aes128(k3, p3)) begin errors++; $display("[TB] FAIL bp_rsp3: got %b %h, expected 1000 %h", rsp_valid, rsp_ciphertext, aes128(k3, p3)); end
    handshake(3);
    exp_ptr = 0;
  endtask

  task automatic test_spurious();
    logic [127:0] k, p;
    bit got;
    @(negedge clk);
    spur_ct = rand128();
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== '0 || core_start !== 1'b0) begin errors++; $display("[TB] FAIL spur_idle_%0d: got valid %b start %b, expected 0 0", c, rsp_valid, core_start); end
    end
    k = rand128(); p = rand128();
    set_req(1, k, p);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== oh(model_pick(4'b0010, exp_ptr))) begin errors++; $display("[TB] FAIL spur_grant: got %b, expected 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(got);
    checks++; if (!got || rsp_valid !== 4'b0010 || rsp_ciphertext !== aes128(k, p)) begin errors++; $display("[TB] FAIL spur_rsp: got %b %h, expected 0010 %h", rsp_valid, rsp_ciphertext, aes128(k, p)); end
    handshake(1);
    exp_ptr = 2;
  endtask

  task automatic test_reset_in_wait();
    logic [127:0] k1, p1, k3, p3;
    int g;
    bit got;
    @(negedge clk);
    set_req(2, rand128(), rand128());
    req_valid = 4'b0100;
    core_mute = 1'b1;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== '0 || req_ready !== '0 || core_start !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rstw_ctrl: got valid %b ready %b start %b err %b, expected 0", rsp_valid, req_ready, core_start, rsp_err); end
    checks++; if (core_key !== '0 || core_plaintext !== '0 || rsp_ciphertext !== '0) begin errors++; $display("[TB] FAIL rstw_data: got key %h pt %h ct %h, expected 0", core_key, core_plaintext, rsp_ciphertext); end
    rst = 1'b0;
    core_mute = 1'b0;
    exp_ptr = 0;
    k1 = rand128(); p1 = rand128(); k3 = rand128(); p3 = rand128();
    set_req(1, k1, p1);
    set_req(3, k3, p3);
    req_valid = 4'b1010;
    #1;
    g = model_pick(req_valid, exp_ptr);
    checks++; if (req_ready !== oh(g)) begin errors++; $display("[TB] FAIL rstw_grant: got %b, expected %b", req_ready, oh(g)); end
    @(negedge clk);
    req_valid[g] = 1'b0;
    wait_rsp(got);
    checks++; if (!got || rsp_valid !== oh(g) || rsp_ciphertext !== aes128(k1, p1)) begin errors++; $display("[TB] FAIL rstw_rsp: got %b %h, expected %b %h", rsp_valid, rsp_ciphertext, oh(g), aes128(k1, p1)); end
    handshake(g);
    exp_ptr = (g + 1) % N;
    #1;
    g = model_pick(req_valid, exp_ptr);
    checks++; if (req_ready !== oh(g)) begin errors++; $display("[TB] FAIL rstw_grant2: got %b, expected %b", req_ready, oh(g)); end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(got);
    checks++; if (!got || rsp_valid !== oh(g) || rsp_ciphertext !== aes128(k3, p3)) begin errors++; $display("[TB] FAIL rstw_rsp2: got %b %h, expected %b %h", rsp_valid, rsp_ciphertext, oh(g), aes128(k3, p3)); end
    handshake(g);
    exp_ptr = (g + 1) % N;
  endtask

  task automatic test_timeout();
    int rsp_cyc;
`ifdef AES_ARB_TIMEOUT_EN
    logic [127:0] k, p;
    bit got;
`else
    int seen;
`endif
    @(negedge clk);
    set_req(exp_ptr, rand128(), rand128());
    req_valid = oh(exp_ptr);
    core_mute = 1'b1;
    @(negedge clk);
    req_valid = '0;
    rsp_cyc = -1;
`ifdef AES_ARB_TIMEOUT_EN
    // Cycle 1 after accept is ISSUE, WAIT begins at 2, response TO+1 later.
    for (int c = 2; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin rsp_cyc = c; break; end
    end
    checks++; if (rsp_cyc != 2 + TO + 1) begin errors++; $display("[TB] FAIL to_latency: got cycle %0d, expected %0d", rsp_cyc, 2 + TO + 1); end
    checks++; if (rsp_valid !== oh(exp_ptr) || rsp_err !== 1'b1 || rsp_ciphertext !== '0) begin errors++; $display("[TB] FAIL to_rsp: got valid %b err %b ct %h, expected %b 1 0", rsp_valid, rsp_err, rsp_ciphertext, oh(exp_ptr)); end
    handshake(exp_ptr);
    core_mute = 1'b0;
    exp_ptr = (exp_ptr + 1) % N;
    k = rand128(); p = rand128();
    set_req(exp_ptr, k, p);
    req_valid = oh(exp_ptr);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(got);
    checks++; if (!got || rsp_err !== 1'b0 || rsp_ciphertext !== aes128(k, p)) begin errors++; $display("[TB] FAIL to_recover: got err %b ct %h, expected 0 %h", rsp_err, rsp_ciphertext, aes128(k, p)); end
    handshake(exp_ptr);
    exp_ptr = (exp_ptr + 1) % N;
`else
    seen = 0;
    for (int c = 2; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    checks++; if (seen != 0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout: got %0d rsp cycles err %b, expected 0 0", seen, rsp_err); end
    core_mute = 1'b0;
    do_reset();
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_key = '0; req_plaintext = '0;
    build_sbox();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_spurious();
    test_reset_in_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
